// File: rtl/pattern_sequencer_if.sv
// Spawn-request valid/ready handshake between pattern_sequencer (master)
// and the bullet engine (slave).
interface pattern_sequencer_if;
  logic       spawn_valid_out;
  logic       spawn_ready_in;
  logic [4:0] spawn_slot_out;
  logic [2:0] spawn_speed_out;
  logic [1:0] spawn_dir_out;
  logic       spawn_inv_out;

  modport master (
    output spawn_valid_out,
    output spawn_slot_out,
    output spawn_speed_out,
    output spawn_dir_out,
    output spawn_inv_out,
    input  spawn_ready_in
  );

  modport slave (
    input  spawn_valid_out,
    input  spawn_slot_out,
    input  spawn_speed_out,
    input  spawn_dir_out,
    input  spawn_inv_out,
    output spawn_ready_in
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Walks one 24-slot bullet pattern per turn: load from ROM, wait per-slot frame ticks, spawn.
// Optional feature: PATTERN_SEQ_SKIP_EMPTY_EN skips the spawn of slots whose speed is 0.
module pattern_sequencer #(
  parameter int unsigned SLOTS     = 24,
  parameter int unsigned NUM_TURNS = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         abort_in,
  input  logic                         frame_tick_in,
  output logic [$clog2(NUM_TURNS)-1:0] turn_out,
  input  logic                         pat_valid_in,
  input  logic [3*SLOTS-1:0]           pat_timing_in,
  input  logic [3*SLOTS-1:0]           pat_speed_in,
  input  logic [2*SLOTS-1:0]           pat_direction_in,
  input  logic [SLOTS-1:0]             pat_inversed_in,
  pattern_sequencer_if.master          spawn,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         miss_out
);

  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned TURN_W = $clog2(NUM_TURNS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(NUM_TURNS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SPAWN,
    ST_DONE
  } state_t;

  state_t            state;
  logic [SLOT_W-1:0] slot;
  logic [2:0]        tick_cnt;

  logic [2:0] timing_q [SLOTS];
  logic [2:0] speed_q  [SLOTS];
  logic [1:0] dir_q    [SLOTS];
  logic       inv_q    [SLOTS];

  logic [TURN_W-1:0] next_turn;
  logic              skip_slot;
  logic              last_slot;

  always_comb begin
    next_turn = (turn_out == LAST_TURN) ? '0 : turn_out + TURN_W'(1);
    last_slot = (slot == LAST_SLOT);
  end

`ifdef PATTERN_SEQ_SKIP_EMPTY_EN
  always_comb skip_slot = (speed_q[slot] == '0);
`else
  always_comb skip_slot = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                 <= ST_IDLE;
      turn_out              <= '0;
      slot                  <= '0;
      tick_cnt              <= '0;
      busy_out              <= 1'b0;
      done_out              <= 1'b0;
      miss_out              <= 1'b0;
      spawn.spawn_valid_out <= 1'b0;
      spawn.spawn_slot_out  <= '0;
      spawn.spawn_speed_out <= '0;
      spawn.spawn_dir_out   <= '0;
      spawn.spawn_inv_out   <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        timing_q[i] <= '0;
        speed_q[i]  <= '0;
        dir_q[i]    <= '0;
        inv_q[i]    <= 1'b0;
      end
    end else begin
      done_out <= 1'b0;
      miss_out <= 1'b0;

      if (abort_in) begin
        state                 <= ST_IDLE;
        busy_out              <= 1'b0;
        spawn.spawn_valid_out <= 1'b0;
        slot                  <= '0;
        tick_cnt              <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_in) begin
              state    <= ST_LOAD;
              busy_out <= 1'b1;
            end
          end

          ST_LOAD: begin
            if (pat_valid_in) begin
              for (int unsigned i = 0; i < SLOTS; i++) begin
                timing_q[i] <= pat_timing_in[3*i +: 3];
                speed_q[i]  <= pat_speed_in[3*i +: 3];
                dir_q[i]    <= pat_direction_in[2*i +: 2];
                inv_q[i]    <= pat_inversed_in[i];
              end
              slot     <= '0;
              tick_cnt <= '0;
              state    <= ST_WAIT;
            end else begin
              miss_out <= 1'b1;
              turn_out <= next_turn;
              busy_out <= 1'b0;
              state    <= ST_IDLE;
            end
          end

          // Counter saturates at the slot's timing; leaving happens on the edge after it matches.
          ST_WAIT: begin
            if (tick_cnt == timing_q[slot]) begin
              if (skip_slot) begin
                if (last_slot) begin
                  done_out <= 1'b1;
                  state    <= ST_DONE;
                end else begin
                  slot     <= slot + SLOT_W'(1);
                  tick_cnt <= '0;
                end
              end else begin
                spawn.spawn_valid_out <= 1'b1;
                spawn.spawn_slot_out  <= 5'(slot);
                spawn.spawn_speed_out <= speed_q[slot];
                spawn.spawn_dir_out   <= dir_q[slot];
                spawn.spawn_inv_out   <= inv_q[slot];
                state                 <= ST_SPAWN;
              end
            end else if (frame_tick_in) begin
              tick_cnt <= tick_cnt + 3'd1;
            end
          end

          ST_SPAWN: begin
            if (spawn.spawn_ready_in) begin
              spawn.spawn_valid_out <= 1'b0;
              if (last_slot) begin
                done_out <= 1'b1;
                state    <= ST_DONE;
              end else begin
                slot     <= slot + SLOT_W'(1);
                tick_cnt <= '0;
                state    <= ST_WAIT;
              end
            end
          end

          ST_DONE: begin
            turn_out <= next_turn;
            busy_out <= 1'b0;
            slot     <= '0;
            state    <= ST_IDLE;
          end

          default: begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: vector table, directed corner sequences,
// and randomized turns checked against a rule-based timeline model.
module tb_pattern_sequencer;
  localparam int SLOTS = 24;
  localparam int MAXC  = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        tick;
  logic [3:0]  turn;
  logic        pat_valid;
  logic [71:0] pat_timing;
  logic [71:0] pat_speed;
  logic [47:0] pat_dir;
  logic [23:0] pat_inv;
  logic        busy;
  logic        done;
  logic        miss;

  always #5 clk = ~clk;

  pattern_sequencer_if sif ();

  pattern_sequencer #(.SLOTS(24), .NUM_TURNS(16)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .abort_in        (abort),
    .frame_tick_in   (tick),
    .turn_out        (turn),
    .pat_valid_in    (pat_valid),
    .pat_timing_in   (pat_timing),
    .pat_speed_in    (pat_speed),
    .pat_direction_in(pat_dir),
    .pat_inversed_in (pat_inv),
    .spawn           (sif),
    .busy_out        (busy),
    .done_out        (done),
    .miss_out        (miss)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle stimulus and observations; obs[c] = outputs during cycle c of a run.
  bit          start_a [MAXC];
  bit          tick_a  [MAXC];
  bit          ready_a [MAXC];
  bit          abort_a [MAXC];
  logic [14:0] obs     [MAXC];
  logic [3:0]  obs_turn[MAXC];
  logic [14:0] exp_o   [MAXC];
  bit          exp_v   [MAXC];
  bit          scramble;

  int d_tim[SLOTS];
  int d_spd[SLOTS];
  int d_dir[SLOTS];
  int d_inv[SLOTS];

  typedef struct {
    bit pv;
    int tim;
    int spd;
    int dir;
    int inv;
    int exp_first;
    int exp_done;
    int exp_miss;
    int exp_spawns;
  } vec_t;

  vec_t tbl[4];

  // {miss, busy, done, valid, slot[4:0], speed[2:0], dir[1:0], inv}
  function automatic logic [14:0] pack_out();
    return {miss, busy, done, sif.spawn_valid_out, sif.spawn_slot_out,
            sif.spawn_speed_out, sif.spawn_dir_out, sif.spawn_inv_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      start_a[c] = 1'b0;
      tick_a[c]  = 1'b0;
      ready_a[c] = 1'b0;
      abort_a[c] = 1'b0;
    end
    scramble = 1'b0;
  endtask

  task automatic set_uniform(input int tim, input int spd, input int dir, input int inv);
    for (int k = 0; k < SLOTS; k++) begin
      d_tim[k] = tim;
      d_spd[k] = spd;
      d_dir[k] = dir;
      d_inv[k] = inv;
    end
  endtask

  task automatic drive_desc();
    for (int k = 0; k < SLOTS; k++) begin
      pat_timing[3*k +: 3] = 3'(d_tim[k]);
      pat_speed[3*k +: 3]  = 3'(d_spd[k]);
      pat_dir[2*k +: 2]    = 2'(d_dir[k]);
      pat_inv[k]           = 1'(d_inv[k]);
    end
  endtask

  // Called at posedge+1; drives cycles 0..ncyc-1 and records obs[0..ncyc].
  task automatic run(input int ncyc);
    logic [95:0] r96;
    obs[0]      = pack_out();
    obs_turn[0] = turn;
    for (int c = 0; c < ncyc; c++) begin
      start              = start_a[c];
      tick               = tick_a[c];
      sif.spawn_ready_in = ready_a[c];
      abort              = abort_a[c];
      if (scramble && c >= 2) begin
        r96        = {$urandom(), $urandom(), $urandom()};
        pat_timing = r96[71:0];
        pat_valid  = r96[95];
        r96        = {$urandom(), $urandom(), $urandom()};
        pat_speed  = r96[71:0];
        pat_dir    = r96[95:48];
        pat_inv    = r96[23:0];
      end
      @(posedge clk);
      #1;
      obs[c+1]      = pack_out();
      obs_turn[c+1] = turn;
    end
    start              = 1'b0;
    tick               = 1'b0;
    abort              = 1'b0;
    sif.spawn_ready_in = 1'b0;
  endtask

  // Timeline of a turn started in cycle 0, built from the slot rules:
  // waiting for slot k starts in cycle w; the t-th tick seen at or after w (in cycle j)
  // puts the request on the bus in cycle j+2 (w+1 when t=0); it stays until the first
  // ready cycle, and the next slot's wait starts the cycle after acceptance.
  function automatic int model();
    int w, t, cnt, j, s, a;
    for (int c = 0; c < MAXC; c++) begin
      exp_o[c] = '0;
      exp_v[c] = 1'b0;
    end
    w = 2;
    for (int k = 0; k < SLOTS; k++) begin
      t = d_tim[k];
      if (t > 0) begin
        cnt = 0;
        j   = w;
        while (j < MAXC - 8) begin
          if (tick_a[j]) cnt++;
          if (cnt == t) break;
          j++;
        end
        s = j + 2;
      end else begin
        s = w + 1;
      end
`ifdef PATTERN_SEQ_SKIP_EMPTY_EN
      if (d_spd[k] == 0) begin
        w = s;
        continue;
      end
`endif
      a = s;
      while (a < MAXC - 8 && !ready_a[a]) a++;
      for (int c = s; c <= a; c++) begin
        exp_v[c]       = 1'b1;
        exp_o[c][11:0] = {1'b1, 5'(k), 3'(d_spd[k]), 2'(d_dir[k]), 1'(d_inv[k])};
      end
      w = a + 1;
    end
    for (int c = 1; c <= w; c++) exp_o[c][13] = 1'b1;
    exp_o[w][12] = 1'b1;
    return w;
  endfunction

  initial begin
    int first, donec, missc, spawns, order_err, field_err, t0, dcy, c51, c71, acc2;
    logic [14:0] slot2_exp;

    tbl[0] = '{pv: 1'b1, tim: 0, spd: 5, dir: 1, inv: 0, exp_first: 3, exp_done: 50,  exp_miss: -1, exp_spawns: 24};
    tbl[1] = '{pv: 1'b1, tim: 1, spd: 7, dir: 3, inv: 1, exp_first: 4, exp_done: 74,  exp_miss: -1, exp_spawns: 24};
    tbl[2] = '{pv: 1'b1, tim: 3, spd: 2, dir: 0, inv: 1, exp_first: 6, exp_done: 122, exp_miss: -1, exp_spawns: 24};
    tbl[3] = '{pv: 1'b0, tim: 0, spd: 3, dir: 2, inv: 0, exp_first: -1, exp_done: -1, exp_miss: 2,  exp_spawns: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; tick = 1'b0; pat_valid = 1'b0;
    pat_timing = '0; pat_speed = '0; pat_dir = '0; pat_inv = '0;
    sif.spawn_ready_in = 1'b0;
    clear_stim();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(pack_out()), 32'h0);
    check("reset_turn", 32'(turn), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", 32'(pack_out()), 32'h0);

    // Vector table: uniform descriptors, ticks every cycle, ready tied high
    for (int r = 0; r < 4; r++) begin
      clear_stim();
      set_uniform(tbl[r].tim, tbl[r].spd, tbl[r].dir, tbl[r].inv);
      drive_desc();
      pat_valid  = tbl[r].pv;
      start_a[0] = 1'b1;
      for (int c = 0; c < MAXC; c++) begin
        tick_a[c]  = 1'b1;
        ready_a[c] = 1'b1;
      end
      t0 = int'(turn);
      run(130);
      first = -1; donec = -1; missc = -1; spawns = 0; order_err = 0; field_err = 0;
      for (int c = 0; c <= 130; c++) begin
        if (obs[c][11]) begin
          if (first < 0) first = c;
          if (obs[c][10:6] != 5'(spawns)) order_err++;
          if (obs[c][5:0] != {3'(tbl[r].spd), 2'(tbl[r].dir), 1'(tbl[r].inv)}) field_err++;
          spawns++;
        end
        if (obs[c][12] && donec < 0) donec = c;
        if (obs[c][14] && missc < 0) missc = c;
      end
      check($sformatf("tbl%0d_first_valid", r), first, tbl[r].exp_first);
      check($sformatf("tbl%0d_done_cycle", r), donec, tbl[r].exp_done);
      check($sformatf("tbl%0d_miss_cycle", r), missc, tbl[r].exp_miss);
      check($sformatf("tbl%0d_spawns", r), spawns, tbl[r].exp_spawns);
      check($sformatf("tbl%0d_slot_order_errs", r), order_err, 0);
      check($sformatf("tbl%0d_field_errs", r), field_err, 0);
      check($sformatf("tbl%0d_turn_next", r), 32'(obs_turn[130]), (t0 + 1) % 16);
    end

    // Slot 0 timing 5, slot 1 timing 2, one tick every 10 cycles
    clear_stim();
    set_uniform(0, 1, 0, 0);
    d_tim[0] = 5;
    d_tim[1] = 2;
    drive_desc();
    pat_valid  = 1'b1;
    start_a[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      tick_a[c]  = ((c % 10) == 9);
      ready_a[c] = 1'b1;
    end
    run(120);
    c51 = -1; c71 = -1; donec = -1;
    for (int c = 0; c <= 120; c++) begin
      if (obs[c][11] && obs[c][10:6] == 5'd0 && c51 < 0) c51 = c;
      if (obs[c][11] && obs[c][10:6] == 5'd1 && c71 < 0) c71 = c;
      if (obs[c][12] && donec < 0) donec = c;
    end
    check("tick5_slot0_spawn_cycle", c51, 51);
    check("tick2_slot1_spawn_cycle", c71, 71);
    check("tick_seq_done_cycle", donec, 116);

    // Ready withheld for 7 cycles on slot 2
    clear_stim();
    set_uniform(0, 1, 1, 0);
    d_spd[2] = 6; d_dir[2] = 2; d_inv[2] = 1;
    drive_desc();
    pat_valid  = 1'b1;
    start_a[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) ready_a[c] = !(c >= 7 && c <= 13);
    run(60);
    slot2_exp = {1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 3'd6, 2'd2, 1'b1};
    for (int c = 7; c <= 14; c++) check($sformatf("hold_slot2_cyc%0d", c), 32'(obs[c]), 32'(slot2_exp));
    acc2 = 0;
    for (int c = 0; c <= 60; c++) if (obs[c][11] && obs[c][10:6] == 5'd2 && ready_a[c]) acc2++;
    check("hold_single_accept", acc2, 1);
    check("hold_gap_after_accept", 32'(obs[15][11]), 32'h0);
    check("hold_next_slot", 32'(obs[16][11:6]), 32'({1'b1, 5'd3}));
    donec = -1;
    for (int c = 0; c <= 60; c++) if (obs[c][12] && donec < 0) donec = c;
    check("hold_done_cycle", donec, 57);

    // Abort in WAIT at slot 10 with a simultaneous start, then restart
    clear_stim();
    set_uniform(0, 2, 1, 1);
    d_tim[10] = 7;
    drive_desc();
    pat_valid   = 1'b1;
    start_a[0]  = 1'b1;
    abort_a[25] = 1'b1;
    start_a[25] = 1'b1;
    start_a[28] = 1'b1;
    abort_a[33] = 1'b1;
    for (int c = 0; c < MAXC; c++) ready_a[c] = 1'b1;
    t0 = int'(turn);
    run(40);
    check("abort_waiting_slot10", 32'(obs[24][14:11]), 32'b0100);
    check("abort_idle_next", 32'(obs[26][14:11]), 32'h0);
    check("abort_turn_kept", 32'(obs_turn[26]), t0);
    check("restart_slot0", 32'(obs[31][11:6]), 32'({1'b1, 5'd0}));
    check("abort2_idle", 32'(obs[34][14:11]), 32'h0);
    donec = 0;
    for (int c = 0; c <= 40; c++) if (obs[c][12]) donec++;
    check("abort_no_done", donec, 0);
    check("abort_turn_final", 32'(obs_turn[40]), t0);

    // Advance to turn 15 via misses, then the wrapping miss
    for (int i = 0; i < 16 && turn != 4'd15; i++) begin
      clear_stim();
      pat_valid  = 1'b0;
      start_a[0] = 1'b1;
      run(3);
    end
    clear_stim();
    pat_valid  = 1'b0;
    start_a[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      ready_a[c] = 1'b1;
      tick_a[c]  = 1'b1;
    end
    run(6);
    check("miss15_turn_before", 32'(obs_turn[1]), 32'd15);
    check("miss15_load_busy", 32'(obs[1][14:11]), 32'b0100);
    check("miss15_pulse", 32'(obs[2][14:11]), 32'b1000);
    check("miss15_turn_wrap", 32'(obs_turn[2]), 32'd0);
    check("miss15_one_cycle", 32'(obs[3][14:11]), 32'h0);

`ifdef PATTERN_SEQ_SKIP_EMPTY_EN
    // All slots empty: nothing spawned, turn still completes
    clear_stim();
    set_uniform(0, 0, 3, 1);
    drive_desc();
    pat_valid  = 1'b1;
    start_a[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) ready_a[c] = 1'b1;
    t0 = int'(turn);
    run(30);
    spawns = 0; donec = -1;
    for (int c = 0; c <= 30; c++) begin
      if (obs[c][11]) spawns++;
      if (obs[c][12] && donec < 0) donec = c;
    end
    check("skip_no_valid", spawns, 0);
    check("skip_done_cycle", donec, 26);
    check("skip_turn_next", 32'(obs_turn[27]), (t0 + 1) % 16);
`endif

    // Randomized turns against the timeline model; ROM scrambled after LOAD
    for (int r = 0; r < 3; r++) begin
      clear_stim();
      for (int k = 0; k < SLOTS; k++) begin
        d_tim[k] = int'($urandom_range(0, 3));
        d_spd[k] = int'($urandom_range(0, 7));
        d_dir[k] = int'($urandom_range(0, 3));
        d_inv[k] = int'($urandom_range(0, 1));
      end
      drive_desc();
      pat_valid  = 1'b1;
      start_a[0] = 1'b1;
      for (int c = 0; c < MAXC; c++) begin
        tick_a[c]  = ($urandom_range(0, 2) == 0) || ((c % 4) == 0);
        ready_a[c] = ($urandom_range(0, 1) == 1) || ((c % 3) == 0);
      end
      dcy = model();
      t0  = int'(turn);
      scramble = 1'b1;
      run(dcy + 3);
      scramble = 1'b0;
      for (int c = 0; c <= dcy + 2; c++) begin
        if (exp_v[c]) check($sformatf("rand%0d_cyc%0d", r, c), 32'(obs[c]), 32'(exp_o[c]));
        else check($sformatf("rand%0d_cyc%0d", r, c), 32'(obs[c][14:11]), 32'(exp_o[c][14:11]));
      end
      check($sformatf("rand%0d_turn_hold", r), 32'(obs_turn[dcy]), t0);
      check($sformatf("rand%0d_turn_next", r), 32'(obs_turn[dcy + 1]), (t0 + 1) % 16);
    end

    // Asynchronous reset while slot 5 is being offered
    clear_stim();
    set_uniform(0, 4, 1, 0);
    drive_desc();
    pat_valid  = 1'b1;
    start_a[0] = 1'b1;
    for (int c = 0; c < MAXC; c++) ready_a[c] = (c < 13);
    run(15);
    check("pre_reset_slot5_valid", 32'(obs[14][13:6]), 32'({1'b1, 1'b0, 1'b1, 5'd5}));
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(pack_out()), 32'h0);
    check("async_reset_turn", 32'(turn), 32'h0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", 32'(pack_out()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
